// File: rtl/sfp_accum_bank_if.sv
// Stream bundle for sfp_accum_bank: psum vectors in, drained rows out, both valid/ready.
// The slave modport is the bank's view; the master modport is the feeder/sink side.
interface sfp_accum_bank_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int AW      = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [col*psum_bw-1:0] in_data;
  logic [AW-1:0]          in_addr;
  logic                   in_first;
  logic                   out_valid;
  logic                   out_ready;
  logic [col*psum_bw-1:0] out_data;
  logic [AW-1:0]          out_addr;

  modport master (
    output in_valid, in_data, in_addr, in_first, out_ready,
    input  in_ready, out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_data, in_addr, in_first, out_ready,
    output in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/sfp_accum_bank.sv
// Banked saturating psum accumulators (one row per pixel address); writes land in one cycle.
// Drain streams rows in address order with optional ReLU; out_ready low holds the current row.
module sfp_accum_bank #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int AW      = 4
) (
  input  logic              clk,
  input  logic              reset,
  sfp_accum_bank_if.slave   bus,
  input  logic              drain,
  input  logic              relu_en,
  input  logic              ovf_clr,
  output logic              ovf
);
  localparam int DEPTH = 1 << AW;
  localparam int W     = col * psum_bw;
  localparam logic [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};
  localparam logic [AW-1:0]      LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_ACC, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  row_q [DEPTH];
  logic [W-1:0]  row_d [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  logic          relu_q, relu_d;
  logic          ovf_q, ovf_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [psum_bw-1:0] lane_in, lane_acc;
  logic [psum_bw:0]   lane_sum;
  logic [W-1:0]       out_data_c;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    relu_d   = relu_q;
    ovf_d    = ovf_q & ~ovf_clr;
    row_d    = row_q;
    lane_in  = '0;
    lane_acc = '0;
    lane_sum = '0;

    // Only accepted in ACC, so a write never collides with the drain clear below.
    if (bus.in_valid && in_ready_q) begin
      for (int k = 0; k < col; k++) begin
        lane_in  = bus.in_data[k*psum_bw +: psum_bw];
        lane_acc = row_q[bus.in_addr][k*psum_bw +: psum_bw];
        lane_sum = {lane_acc[psum_bw-1], lane_acc} + {lane_in[psum_bw-1], lane_in};
        if (bus.in_first) begin
          row_d[bus.in_addr][k*psum_bw +: psum_bw] = lane_in;
        end else if (lane_sum[psum_bw] != lane_sum[psum_bw-1]) begin
          row_d[bus.in_addr][k*psum_bw +: psum_bw] = lane_sum[psum_bw] ? SAT_MIN : SAT_MAX;
          ovf_d = 1'b1;
        end else begin
          row_d[bus.in_addr][k*psum_bw +: psum_bw] = lane_sum[psum_bw-1:0];
        end
      end
    end

    case (state_q)
      ST_ACC: begin
        if (drain) begin
          state_d = ST_DRAIN;
          relu_d  = relu_en;
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          row_d[ptr_q] = '0;
          ptr_d        = ptr_q + AW'(1);
          if (ptr_q == LAST) begin
            state_d = ST_ACC;
          end
        end
      end
      default: state_d = ST_ACC;
    endcase

    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACC;
      ptr_q       <= '0;
      relu_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        row_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      relu_q      <= relu_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      row_q       <= row_d;
    end
  end

  // ReLU is applied on the way out only; the stored row keeps its signed value.
  always_comb begin
    out_data_c = out_valid_q ? row_q[ptr_q] : '0;
    if (relu_q) begin
      for (int k = 0; k < col; k++) begin
        if (out_data_c[k*psum_bw + psum_bw - 1]) begin
          out_data_c[k*psum_bw +: psum_bw] = '0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_valid_q ? ptr_q : '0;
  assign bus.out_data  = out_data_c;
  assign ovf           = ovf_q;
endmodule
